npn_tt_sweeper: RTL and testbench

Sequential truth-table capture stage that sits directly upstream of a 4-input single-output exact AIG block (inputs x0..x3, output y0). It sweeps all 16 minterms onto the block's inputs, applying a programmable NPN transform (input permutation, input negation, output negation). It samples y0 for each minterm, assembles the 16-bit truth table and compares it against an expected table. Used for on-chip self-check and NPN-class equivalence of the combinational library cells.

---
 rtl/npn_tt_sweeper.sv | 154 +++++++++++++++
 tb/tb_npn_tt_sweeper.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/npn_tt_sweeper.sv
// Sweeps all 16 minterms through an NPN transform onto a 4-input AIG cell and
// captures its 16-bit truth table, comparing it bit by bit against a reference.
module npn_tt_sweeper #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  perm,
    input  logic [3:0]  neg_mask,
    input  logic        out_neg,
    input  logic [15:0] expected,
    output logic        x0,
    output logic        x1,
    output logic        x2,
    output logic        x3,
    input  logic        y0,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt,
    output logic        match,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_fail,
    output logic        first_fail_valid
);

    typedef enum logic [1:0] {IDLE, HOLD, FINISH} state_t;

    localparam logic [3:0] SETTLE_W = 4'(SETTLE);

    state_t      state_q, state_d;
    logic [3:0]  m_q, m_d;
    logic [3:0]  hold_q, hold_d;
    logic [7:0]  perm_q, perm_d;
    logic [3:0]  neg_q, neg_d;
    logic        oneg_q, oneg_d;
    logic [15:0] exp_q, exp_d;
    logic [15:0] tt_q, tt_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  ff_q, ff_d;
    logic        ffv_q, ffv_d;
    logic        match_q, match_d;
    logic [3:0]  x_vec;
    logic        cap_bit;

    // Stimulus comes only from registered state, so it is glitch-free per minterm.
    always_comb begin
        x_vec = '0;
        if (state_q == HOLD) begin
            for (int i = 0; i < 4; i++) begin
                x_vec[i] = m_q[perm_q[2*i +: 2]] ^ neg_q[i];
            end
        end
    end

    assign cap_bit = y0 ^ oneg_q;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        hold_d  = hold_q;
        perm_d  = perm_q;
        neg_d   = neg_q;
        oneg_d  = oneg_q;
        exp_d   = exp_q;
        tt_d    = tt_q;
        cnt_d   = cnt_q;
        ff_d    = ff_q;
        ffv_d   = ffv_q;
        match_d = match_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    perm_d  = perm;
                    neg_d   = neg_mask;
                    oneg_d  = out_neg;
                    exp_d   = expected;
                    tt_d    = '0;
                    cnt_d   = '0;
                    ff_d    = '0;
                    ffv_d   = 1'b0;
                    match_d = 1'b0;
                    m_d     = '0;
                    hold_d  = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hold_q != SETTLE_W) begin
                    hold_d = hold_q + 4'd1;
                end else begin
                    tt_d[m_q] = cap_bit;
                    if (cap_bit != exp_q[m_q]) begin
                        cnt_d = cnt_q + 5'd1;
                        if (!ffv_q) begin
                            ff_d  = m_q;
                            ffv_d = 1'b1;
                        end
                    end
                    if (m_q == 4'd15) begin
                        // Resolve match here so it is already valid in the done cycle.
                        match_d = (cnt_d == 5'd0);
                        state_d = FINISH;
                    end else begin
                        m_d    = m_q + 4'd1;
                        hold_d = '0;
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            hold_q  <= '0;
            perm_q  <= '0;
            neg_q   <= '0;
            oneg_q  <= 1'b0;
            exp_q   <= '0;
            tt_q    <= '0;
            cnt_q   <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            hold_q  <= hold_d;
            perm_q  <= perm_d;
            neg_q   <= neg_d;
            oneg_q  <= oneg_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            cnt_q   <= cnt_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
            match_q <= match_d;
        end
    end

    assign {x3, x2, x1, x0}  = x_vec;
    assign busy             = (state_q == HOLD);
    assign done             = (state_q == FINISH);
    assign tt               = tt_q;
    assign match            = match_q;
    assign mismatch_cnt     = cnt_q;
    assign first_fail       = ff_q;
    assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_npn_tt_sweeper.sv
// Bench for npn_tt_sweeper: a SETTLE=1 and a SETTLE=0 instance, each driving a
// behavioural AIG cell, checked against a truth-table reference model.
module tb_npn_tt_sweeper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start0 = 1'b0, start1 = 1'b0;
    logic [7:0]  perm = '0;
    logic [3:0]  neg_mask = '0;
    logic        out_neg = 1'b0;
    logic [15:0] expected = '0;
    logic        model_sel = 1'b0;   // 0: AIG function, 1: y0 = x3 (instance 1 only)

    logic        a_x0, a_x1, a_x2, a_x3, a_y0, a_busy, a_done, a_match, a_ffv;
    logic [15:0] a_tt;
    logic [4:0]  a_cnt;
    logic [3:0]  a_ff;
    logic        b_x0, b_x1, b_x2, b_x3, b_y0, b_busy, b_done, b_match, b_ffv;
    logic [15:0] b_tt;
    logic [4:0]  b_cnt;
    logic [3:0]  b_ff;

    int checks = 0;
    int errors = 0;

    function automatic logic aig(input logic [3:0] x);
        logic maj, par;
        maj = (x[1] & x[2]) | (x[1] & x[3]) | (x[2] & x[3]);
        par = x[1] ^ x[2] ^ x[3];
        return x[0] ? ~maj : ~par;
    endfunction

    function automatic logic [15:0] ref_tt(input logic sel, input logic [7:0] p,
                                           input logic [3:0] n, input logic o);
        logic [15:0] r;
        logic [3:0]  x, mt;
        for (int m = 0; m < 16; m++) begin
            mt = 4'(m);
            for (int i = 0; i < 4; i++) x[i] = mt[p[2*i +: 2]] ^ n[i];
            r[m] = (sel ? x[3] : aig(x)) ^ o;
        end
        return r;
    endfunction

    assign a_y0 = aig({a_x3, a_x2, a_x1, a_x0});
    assign b_y0 = model_sel ? b_x3 : aig({b_x3, b_x2, b_x1, b_x0});

    npn_tt_sweeper #(.SETTLE(1)) u0 (
        .clk(clk), .rst(rst), .start(start0), .perm(perm), .neg_mask(neg_mask),
        .out_neg(out_neg), .expected(expected),
        .x0(a_x0), .x1(a_x1), .x2(a_x2), .x3(a_x3), .y0(a_y0),
        .busy(a_busy), .done(a_done), .tt(a_tt), .match(a_match),
        .mismatch_cnt(a_cnt), .first_fail(a_ff), .first_fail_valid(a_ffv)
    );

    npn_tt_sweeper #(.SETTLE(0)) u1 (
        .clk(clk), .rst(rst), .start(start1), .perm(perm), .neg_mask(neg_mask),
        .out_neg(out_neg), .expected(expected),
        .x0(b_x0), .x1(b_x1), .x2(b_x2), .x3(b_x3), .y0(b_y0),
        .busy(b_busy), .done(b_done), .tt(b_tt), .match(b_match),
        .mismatch_cnt(b_cnt), .first_fail(b_ff), .first_fail_valid(b_ffv)
    );

    int          inst = 0;
    logic        c_busy, c_done, c_match, c_ffv;
    logic [15:0] c_tt;
    logic [4:0]  c_cnt;
    logic [3:0]  c_ff;
    always_comb begin
        c_busy  = inst ? b_busy  : a_busy;
        c_done  = inst ? b_done  : a_done;
        c_match = inst ? b_match : a_match;
        c_ffv   = inst ? b_ffv   : a_ffv;
        c_tt    = inst ? b_tt    : a_tt;
        c_cnt   = inst ? b_cnt   : a_cnt;
        c_ff    = inst ? b_ff    : a_ff;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (inst == 0) start0 = v; else start1 = v;
    endtask

    // Starts a sweep, scrambles config after acceptance, checks busy/done timing
    // and returns at the negedge of the done cycle.
    task automatic run_sweep(input int which, input logic [7:0] p, input logic [3:0] n,
                             input logic o, input logic [15:0] e, input int restart_at);
        int settle, k, bc;
        inst   = which;
        settle = (which == 0) ? 1 : 0;
        @(negedge clk);
        perm = p; neg_mask = n; out_neg = o; expected = e;
        set_start(1'b1);
        @(negedge clk);
        perm = 8'($urandom); neg_mask = 4'($urandom); out_neg = 1'($urandom);
        expected = 16'($urandom);
        k = 1; bc = 0;
        while (!c_done && k < 16 * (settle + 1) + 20) begin
            set_start(k == restart_at);
            if (c_busy) bc++;
            @(negedge clk);
            k++;
        end
        set_start(1'b0);
        chk("done_cycle", k, 16 * (settle + 1) + 1);
        chk("busy_len", bc, 16 * (settle + 1));
        chk("busy_in_done", c_busy, 0);
    endtask

    typedef struct {
        int          which;
        logic        sel;
        logic [7:0]  p;
        logic [3:0]  n;
        logic        o;
        logic [15:0] e;
        logic [15:0] tt;
        logic [4:0]  cnt;
        logic [3:0]  ff;
        logic        ffv;
        logic        match;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [15:0] r, e, d;
        logic [7:0]  p;
        logic [3:0]  n, lo;
        logic        o;
        int          dcount;

        vecs[0] = '{0, 1'b0, 8'hE4, 4'h0, 1'b0, 16'h166B, 16'h166B, 5'd0,  4'd0,  1'b0, 1'b1};
        vecs[1] = '{0, 1'b0, 8'hE4, 4'h0, 1'b1, 16'h166B, 16'hE994, 5'd16, 4'd0,  1'b1, 1'b0};
        vecs[2] = '{0, 1'b0, 8'hE4, 4'h1, 1'b0, 16'h2997, 16'h2997, 5'd0,  4'd0,  1'b0, 1'b1};
        vecs[3] = '{0, 1'b0, 8'hE4, 4'h0, 1'b0, 16'h166A, 16'h166B, 5'd1,  4'd0,  1'b1, 1'b0};
        vecs[4] = '{0, 1'b0, 8'hE4, 4'h0, 1'b0, 16'h966B, 16'h166B, 5'd1,  4'd15, 1'b1, 1'b0};
        vecs[5] = '{1, 1'b1, 8'hE4, 4'h0, 1'b0, 16'hFF00, 16'hFF00, 5'd0,  4'd0,  1'b0, 1'b1};

        #12;
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_x", {a_x3, a_x2, a_x1, a_x0}, 0);
        chk("rst_results", {a_tt, a_match, a_cnt, a_ff, a_ffv}, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            model_sel = vecs[i].sel;
            run_sweep(vecs[i].which, vecs[i].p, vecs[i].n, vecs[i].o, vecs[i].e, 0);
            chk("vec_tt", c_tt, vecs[i].tt);
            chk("vec_cnt", c_cnt, vecs[i].cnt);
            chk("vec_ff", c_ff, vecs[i].ff);
            chk("vec_ffv", c_ffv, vecs[i].ffv);
            chk("vec_match", c_match, vecs[i].match);
            @(negedge clk);
            chk("done_pulse_len", c_done, 0);
            chk("match_held", c_match, vecs[i].match);
            chk("tt_held", c_tt, vecs[i].tt);
        end
        model_sel = 1'b0;

        // Start pulsed mid-sweep and again in the done cycle: both ignored.
        run_sweep(0, 8'hE4, 4'h0, 1'b0, 16'h166B, 5);
        chk("restart_tt", a_tt, 16'h166B);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        dcount = 0;
        for (int c = 0; c < 40; c++) begin
            if (a_done || a_busy) dcount++;
            @(negedge clk);
        end
        chk("restart_no_second_run", dcount, 0);

        // Asynchronous reset mid-sweep.
        inst = 0;
        perm = 8'hE4; neg_mask = 4'h0; out_neg = 1'b0; expected = 16'h166B;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_pre_busy", a_busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", a_busy, 0);
        chk("abort_done", a_done, 0);
        chk("abort_x", {a_x3, a_x2, a_x1, a_x0}, 0);
        chk("abort_results", {a_tt, a_match, a_cnt, a_ff, a_ffv}, 0);
        dcount = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (a_done || a_busy) dcount++;
            @(negedge clk);
        end
        chk("abort_no_done", dcount, 0);
        run_sweep(0, 8'hE4, 4'h0, 1'b0, 16'h166B, 0);
        chk("post_abort_tt", a_tt, 16'h166B);
        chk("post_abort_match", a_match, 1);

        // Random NPN configurations against the reference model.
        for (int t = 0; t < 24; t++) begin
            p = 8'($urandom);
            n = 4'($urandom);
            o = 1'($urandom);
            r = ref_tt(1'b0, p, n, o);
            case ($urandom_range(0, 2))
                0: d = '0;
                1: d = 16'(1) << $urandom_range(0, 15);
                default: d = 16'($urandom);
            endcase
            e = r ^ d;
            lo = 4'd0;
            for (int b = 15; b >= 0; b--) if (d[b]) lo = 4'(b);
            run_sweep(t % 2, p, n, o, e, 0);
            chk("rnd_tt", c_tt, r);
            chk("rnd_cnt", c_cnt, $countones(d));
            chk("rnd_ffv", c_ffv, d != 0);
            chk("rnd_ff", c_ff, lo);
            chk("rnd_match", c_match, d == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
